// File: rtl/signal_light_arbiter_if.sv
// Bundle of the arbiter's request inputs and LED/grant outputs.
// master: the requester side (decoder, switches); slave: the arbiter.
interface signal_light_arbiter_if;
    logic       power_now;
    logic [3:0] state;
    logic [3:0] answer;
    logic       hazard_req;
    logic       left_led;
    logic       right_led;
    logic [2:0] grant;

    modport master (
        output power_now,
        output state,
        output answer,
        output hazard_req,
        input  left_led,
        input  right_led,
        input  grant
    );

    modport slave (
        input  power_now,
        input  state,
        input  answer,
        input  hazard_req,
        output left_led,
        output right_led,
        output grant
    );
endinterface

// File: rtl/signal_light_arbiter.sv
// Indicator LED arbiter: one grant FSM picks the owner of the left/right LED pair
// (hazard, turn, reverse) and one shared phase counter generates the blink waveform.
module signal_light_arbiter #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned BLINK_HALF_MS = 500,
    parameter int unsigned MIN_BLINKS    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    signal_light_arbiter_if.slave bus
);

    localparam int unsigned HALF = CLK_HZ / 1000 * BLINK_HALF_MS;
    localparam int unsigned PW   = $clog2(HALF);
    localparam int unsigned BW   = $clog2(MIN_BLINKS + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(HALF - 1);
    localparam logic [BW-1:0] BLINK_MIN  = BW'(MIN_BLINKS);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReady  = 3'd1,
        StLeft   = 3'd2,
        StRight  = 3'd3,
        StHazard = 3'd4,
        StBack   = 3'd5
    } st_e;

    st_e           st_q, st_d;
    logic          phase_q, phase_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          left_q, left_d;
    logic          right_q, right_d;

    logic drive;
    logic left_only;
    logic right_only;
    logic back_req;
    logic off_end;
    logic min_done;

    // Forward bit is not an indicator source.
    logic unused_answer;
    assign unused_answer = bus.answer[0];

    assign drive      = !bus.power_now && (bus.state == 4'b0010 || bus.state == 4'b0100);
    assign left_only  = bus.answer[3] && !bus.answer[2];
    assign right_only = bus.answer[2] && !bus.answer[3];
    // Reverse only when no turn is being granted this cycle.
    assign back_req   = bus.answer[1] && !left_only && !right_only;
    // Last cycle of an off half-period: the only point a turn may release.
    assign off_end    = !phase_q && (phase_cnt_q == PHASE_LAST);
    assign min_done   = (blink_cnt_q >= BLINK_MIN);

    // Grant selection: power-off > hazard > turn > back > ready.
    always_comb begin
        st_d = st_q;
        if (bus.power_now) begin
            st_d = StIdle;
        end else if (st_q == StHazard) begin
            if (!bus.hazard_req) begin
                st_d = drive ? StReady : StIdle;
            end
        end else if (bus.hazard_req) begin
            st_d = StHazard;
        end else if (!drive) begin
            st_d = StIdle;
        end else begin
            unique case (st_q)
                StIdle: st_d = StReady;
                StReady, StBack: begin
                    if (left_only) begin
                        st_d = StLeft;
                    end else if (right_only) begin
                        st_d = StRight;
                    end else if (back_req) begin
                        st_d = StBack;
                    end else begin
                        st_d = StReady;
                    end
                end
                StLeft: begin
                    if (right_only) begin
                        st_d = StRight;
                    end else if (!bus.answer[3] && min_done && off_end) begin
                        st_d = StReady;
                    end
                end
                StRight: begin
                    if (left_only) begin
                        st_d = StLeft;
                    end else if (!bus.answer[2] && min_done && off_end) begin
                        st_d = StReady;
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    // Blink generator: restarts with a full on-period on every entry to a blinking owner.
    always_comb begin
        phase_d     = 1'b0;
        phase_cnt_d = '0;
        blink_cnt_d = '0;
        if (st_d inside {StLeft, StRight, StHazard}) begin
            if (st_d != st_q) begin
                phase_d = 1'b1;
            end else if (phase_cnt_q == PHASE_LAST) begin
                phase_d     = !phase_q;
                blink_cnt_d = blink_cnt_q;
                if (phase_q && (blink_cnt_q != BLINK_MIN)) begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end else begin
                phase_d     = phase_q;
                phase_cnt_d = phase_cnt_q + PW'(1);
                blink_cnt_d = blink_cnt_q;
            end
        end
    end

    // LED values for the next owner and next phase, so outputs register with the grant.
    always_comb begin
        left_d  = 1'b0;
        right_d = 1'b0;
        unique case (st_d)
            StLeft:   left_d = phase_d;
            StRight:  right_d = phase_d;
            StHazard: begin
                left_d  = phase_d;
                right_d = phase_d;
            end
            StBack: begin
                left_d  = 1'b1;
                right_d = 1'b1;
            end
            default: begin
                left_d  = 1'b0;
                right_d = 1'b0;
            end
        endcase
    end

    // Grant FSM state, blink counters and registered LED outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= StIdle;
            phase_q     <= 1'b0;
            phase_cnt_q <= '0;
            blink_cnt_q <= '0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            phase_q     <= phase_d;
            phase_cnt_q <= phase_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
        end
    end

    assign bus.grant     = st_q;
    assign bus.left_led  = left_q;
    assign bus.right_led = right_q;

endmodule

// File: doc/signal_light_arbiter.md
# signal_light_arbiter

Arbitrates the car's left/right indicator LED pair between the hazard switch, the turn requests and the reverse request, and generates the blink waveform for whichever requester holds the lights. Sits between the manual-drive decoder (`state`, `answer`) and the board LEDs. It supersedes per-function blink dividers with one shared phase counter and one grant state machine.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency.
- `BLINK_HALF_MS`, 500, blink half-period in ms; `HALF = CLK_HZ/1000*BLINK_HALF_MS` cycles, must be ≥ 2.
- `MIN_BLINKS`, 3, on-periods a granted turn signal completes before it may release.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `power_now`  in  1  1 = car powered off; forces IDLE.
- `state`  in  4  car state one-hot: 0001 not started, 0010 starting, 0100 moving, 1000 off.
- `answer`  in  4  [3] left, [2] right, [1] back, [0] forward.
- `hazard_req`  in  1  hazard switch, level.
- `left_led`  out  1  left indicator.
- `right_led`  out  1  right indicator.
- `grant`  out  3  current owner: 0 IDLE, 1 READY, 2 LEFT, 3 RIGHT, 4 HAZARD, 5 BACK.

## Operation
- `drive` = `state`==0010 or 0100; `power_now`=1 overrides everything.
- Priority each cycle: power_off > hazard > turn > back > ready.
- IDLE: leds 0. → HAZARD if `hazard_req` and not `power_now`; → READY if `drive`.
- READY: leds 0. → HAZARD on `hazard_req`; → LEFT if `answer[3]` and not `answer[2]`; → RIGHT if `answer[2]` and not `answer[3]`; both turn bits set = neither granted; → BACK if `answer[1]` and no turn; → IDLE if not `drive`.
- LEFT/RIGHT: own led = blink phase, other led 0. Release to READY only when own request low, `blink_cnt` ≥ MIN_BLINKS, and at the end of an off half-period. Opposite request alone (own request low) → switch directly to opposite turn, min-blink obligation dropped. Not `drive` → IDLE immediately. Hazard pre-empts.
- HAZARD: both leds = blink phase; allowed even when not `drive`. Exit when `hazard_req` low: → READY if `drive`, else IDLE. No min-blink rule.
- BACK: both leds steady 1. Turn request or hazard pre-empts; `answer[1]` low → READY; not `drive` → IDLE.
- Blink generator: `phase_cnt` 0..HALF-1, `phase` toggles when `phase_cnt`==HALF-1 and wraps to 0. On every entry to LEFT/RIGHT/HAZARD, `phase_cnt`←0, `phase`←1, `blink_cnt`←0, so the first on-period is a full HALF cycles.
- `blink_cnt` increments at each on→off toggle, saturates at MIN_BLINKS; width `$clog2(MIN_BLINKS+1)`.
- `power_now`=1 in any state → IDLE at next edge (synchronous), leds 0.

## Timing
- Reset (rst=0, asynchronous): `grant`=0, `left_led`=0, `right_led`=0, `phase`=0, `phase_cnt`=0, `blink_cnt`=0. Release is sampled at the next rising edge.
- Inputs sampled at edge N; `grant` and leds take the new value at edge N (registered, leds computed from next-state and next-phase): one-cycle latency input→output.
- In a blinking state, led is 1 for exactly HALF cycles, 0 for HALF cycles, period 2·HALF.
- Turn release earliest at the edge ending the off half after the MIN_BLINKS-th on-period: entry + 2·HALF·MIN_BLINKS cycles.
- Simultaneous pre-emption and release in one cycle: higher priority wins; counters re-initialise on entry.
- Reset asserted mid-blink: leds drop to 0 asynchronously, no glitch-resume after release.

## Test plan
Use CLK_HZ=1000, BLINK_HALF_MS=4 (HALF=4), MIN_BLINKS=2.
- Reset: rst=0 with all inputs high → grant=0, leds 0; release with state=0100, inputs 0 → grant=1 next edge.
- Left pulse: state=0100, answer=1000 for 1 cycle → grant=2, left_led pattern 1111 0000 1111 0000, then grant=1 at entry+16 cycles; right_led stays 0.
- Both turns: answer=1100 in READY → grant stays 1; then answer=0100 → grant=3, right_led=1 next edge.
- Hazard pre-empt: in LEFT mid on-period assert hazard_req → grant=4 next edge, both leds 1 for 4 cycles then 0 for 4; drop hazard with answer=0 → grant=1.
- Back and override: answer=0010 → grant=5, both leds 1 steady; answer=1010 → grant=2, blinking left; state=0001 → grant=0, leds 0 next edge.
- Power off: in HAZARD with state=0001 assert power_now=1 → grant=0, leds 0 next edge; deassert with hazard_req=1 → grant=4.
